// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// default width and the last CALC iteration index.
package mdu_hilo_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int ITER_LAST = MDU_WIDTH - 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // MULT and DIV (op[0]=0) treat their operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Controller <-> MDU bundle: operation request, MTHI/MTLO writes, status and HI/LO.
interface mdu_hilo_if
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_divstep.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_full;
    logic             unused_rem_top;

    assign shifted  = {rem, msb};
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~diff[WIDTH+1];
    assign rem_full = q_bit ? diff[WIDTH:0] : shifted;
    // The remainder is always below the divisor, so the top bit is zero.
    assign rem_next       = rem_full[WIDTH-1:0];
    assign unused_rem_top = rem_full[WIDTH];
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to compute multiplies in a single cycle (IDLE -> FIX).
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = ITER_LAST + 1
) (
    input  logic        clk,
    input  logic        rst,
    mdu_hilo_if.slave   bus
);
    localparam int CW = $clog2(ITER);

    mdu_state_e       state, state_nx;
    logic [CW-1:0]    cnt;
    logic             is_div, sign_a, sign_b, b_zero, done_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb, hi_q, lo_q;

    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod, res_mul;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic             fast_mult;

    always_comb begin
        sgn     = op_is_signed(bus.op);
        mag_a   = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b   = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        prod    = {acc_hi, acc_lo};
        res_mul = (sign_a ^ sign_b) ? -prod : prod;
    end

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_mult = ~bus.op[1];
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    assign fast_mult = 1'b0;
`endif

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem      (acc_hi),
        .msb      (acc_lo[WIDTH-1]),
        .divisor  (opb),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_CALC) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nx = fast_mult ? S_FIX : S_CALC;
            S_CALC: if (cnt == CW'(ITER - 1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // acc_lo starts as |a| for both ops: multiplier bits shift out of it while
    // product bits shift in; for divides dividend bits shift out, quotient bits in.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done_q <= (state == S_FIX);
            unique case (state)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wd;
                    if (bus.lo_we) lo_q <= bus.wd;
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        sign_a <= sgn & bus.a[WIDTH-1];
                        sign_b <= sgn & bus.b[WIDTH-1];
                        b_zero <= (bus.b == '0);
                        opb    <= mag_b;
`ifdef MDU_FAST_MULT_EN
                        if (fast_mult) begin
                            {acc_hi, acc_lo} <= fast_prod;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                        end
`else
                        acc_hi <= '0;
                        acc_lo <= mag_a;
`endif
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        acc_hi <= rem_next;
                        acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        // A zero divisor subtracts every step, leaving the
                        // remainder equal to |a|; re-signing it restores a.
                        lo_q <= b_zero ? '1 : ((sign_a ^ sign_b) ? -acc_lo : acc_lo);
                        hi_q <= sign_a ? -acc_hi : acc_hi;
                    end else begin
                        hi_q <= res_mul[2*WIDTH-1:WIDTH];
                        lo_q <= res_mul[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases, random ops against a
// 64-bit arithmetic reference, MTHI/MTLO behaviour and mid-operation reset.
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_hilo_if #(.WIDTH(32)) bus();
    mdu_hilo #(.WIDTH(32), .ITER(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, y);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] qv, rv;
        sa = {{32{x[31]}}, x};
        sb = {{32{y[31]}}, y};
        ua = {32'b0, x};
        ub = {32'b0, y};
        case (o)
            2'd0: return sa * sb;
            2'd1: return ua * ub;
            default: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    qv = q; rv = r;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    qv = uq; rv = ur;
                end
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
        if (!o[1]) return 2;
`endif
        return 34;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                          output logic [31:0] rh, rl, output int lat,
                          output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        rh = bus.hi;
        rl = bus.lo;
        @(negedge clk);
        pulse_ok = (bus.done === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  vo [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
        logic [31:0] va [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7,
                                32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] vb [7] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'd0, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] eh [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,
                                32'h12345678, 32'd0, 32'h40000000};
        logic [31:0] el [7] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'd3,
                                32'hFFFFFFFF, 32'h80000000, 32'd0};
        logic [31:0] rh, rl;
        int lat;
        bit bok, pok;
        for (int i = 0; i < 7; i++) begin
            run_op(vo[i], va[i], vb[i], rh, rl, lat, bok, pok);
            vectors++;
            if (rh !== eh[i] || rl !== el[i]) begin
                miscompares++;
                $display("FAIL directed[%0d] hi/lo: got %h/%h want %h/%h", i, rh, rl, eh[i], el[i]);
            end
            vectors++;
            if (lat != exp_lat(vo[i]) || !bok || !pok) begin
                miscompares++;
                $display("FAIL directed[%0d] timing: lat=%0d busy_ok=%b pulse_ok=%b want lat=%0d 1 1",
                         i, lat, bok, pok, exp_lat(vo[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, rh, rl;
        logic [1:0]  o;
        logic [63:0] e;
        int lat;
        bit bok, pok;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = $urandom_range(0, 1000); y = $urandom_range(1, 50); end
                2: y = 32'hFFFFFFFF;
                default: ;
            endcase
            e = ref_model(o, x, y);
            run_op(o, x, y, rh, rl, lat, bok, pok);
            vectors++;
            if (rh !== e[63:32] || rl !== e[31:0] || lat != exp_lat(o) || !bok || !pok) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h/%h lat=%0d want %h/%h lat=%0d",
                         i, o, x, y, rh, rl, lat, e[63:32], e[31:0], exp_lat(o));
            end
        end
    endtask

    task automatic test_mt_write();
        int n;
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wd = 32'hAAAA5555;
        @(negedge clk);
        bus.hi_we = 1'b0;
        vectors++;
        if (bus.hi !== 32'hAAAA5555) begin
            miscompares++;
            $display("FAIL mthi_idle: got %h want aaaa5555", bus.hi);
        end
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h12345678;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        vectors++;
        if (bus.hi !== 32'h12345678 || bus.lo !== 32'h12345678) begin
            miscompares++;
            $display("FAIL mthi_mtlo_both: got %h/%h want 12345678/12345678", bus.hi, bus.lo);
        end
        // DIVU 100/7 started together with MTHI
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd7;
        bus.hi_we = 1'b1; bus.wd = 32'hCAFEF00D;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        vectors++;
        if (bus.hi !== 32'hCAFEF00D || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_with_mthi: hi=%h busy=%b want cafef00d 1", bus.hi, bus.busy);
        end
        repeat (3) @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'hDEADBEEF;
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
        vectors++;
        if (bus.hi !== 32'hCAFEF00D || bus.lo !== 32'h12345678) begin
            miscompares++;
            $display("FAIL mt_while_busy: got %h/%h want cafef00d/12345678", bus.hi, bus.lo);
        end
        n = 5;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 34 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            miscompares++;
            $display("FAIL busy_restart_ignored: lat=%0d hi/lo=%h/%h want 34 00000002/0000000e",
                     n, bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        bit seen;
        logic [31:0] rh, rl;
        int lat;
        bit bok, pok;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'hFFFFFF9C; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL rst_mid_no_done: got activity after reset, want none");
        end
        run_op(2'd1, 32'd3, 32'd5, rh, rl, lat, bok, pok);
        vectors++;
        if (rh !== 32'd0 || rl !== 32'd15 || lat != exp_lat(2'd1)) begin
            miscompares++;
            $display("FAIL after_rst_multu: got %h/%h lat=%0d want 00000000/0000000f lat=%0d",
                     rh, rl, lat, exp_lat(2'd1));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
        test_reset();
        test_directed();
        test_random();
        test_mt_write();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
